// File: rtl/crp16_alu_divider_pkg.sv
// rtl/crp16_alu_divider_pkg.sv - shared encodings and helpers for the crp16 divider
package crp16_alu_divider_pkg;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  localparam logic [15:0] DIV_ZERO_Q = 16'hFFFF;
  localparam int          DIV_CNT_W  = 4;

  function automatic logic [15:0] neg16(input logic [15:0] v);
    return (~v) + 16'd1;
  endfunction

  // Unsigned magnitude of a two's-complement value; 0x8000 maps to 0x8000.
  function automatic logic [15:0] mag16(input logic [15:0] v);
    return v[15] ? neg16(v) : v;
  endfunction

endpackage

// File: rtl/crp16_alu_adder.sv
// rtl/crp16_alu_adder.sv - 16-bit add/subtract unit; c_out=1 on subtract means no borrow
module crp16_alu_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [16:0] total;

  assign total        = {1'b0, a} + {1'b0, b ^ {16{sub}}} + {16'b0, sub};
  assign {c_out, sum} = total;

endmodule

// File: rtl/crp16_alu_divider.sv
// rtl/crp16_alu_divider.sv - multi-cycle restoring divider, one trial subtraction per clock
module crp16_alu_divider
  import crp16_alu_divider_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             div_zero
);

  localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(WIDTH - 1);

  logic [1:0]           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     dvd;
  logic [WIDTH-1:0]     dvs;
  logic                 sq;
  logic                 sr;

  logic                 sgn;
  logic [WIDTH:0]       shifted;
  logic [WIDTH-1:0]     diff;
  logic                 c_out;
  logic                 success;
  logic [WIDTH-1:0]     rem_next;
  logic [WIDTH-1:0]     q_mag;

  assign sgn = SIGNED_EN && signed_op;

  // The 17th bit covers divisors >= 0x8000 whose shifted remainder overflows 16 bits.
  assign shifted  = {rem, dvd[WIDTH-1]};
  assign success  = shifted[WIDTH] | c_out;
  assign rem_next = success ? diff : shifted[WIDTH-1:0];
  assign q_mag    = {dvd[WIDTH-2:0], success};

  crp16_alu_adder u_trial (
    .a     (shifted[WIDTH-1:0]),
    .b     (dvs),
    .sub   (1'b1),
    .sum   (diff),
    .c_out (c_out)
  );

  assign busy = (state != DIV_IDLE);
  assign done = (state == DIV_DONE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      sq       <= 1'b0;
      sr       <= 1'b0;
      q_out    <= '0;
      r_out    <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            sq    <= sgn & (x[WIDTH-1] ^ y[WIDTH-1]);
            sr    <= sgn & x[WIDTH-1];
            dvs   <= sgn ? mag16(y) : y;
            rem   <= '0;
            cnt   <= '0;
            state <= DIV_RUN;
            // A zero divisor keeps the raw dividend so it can be returned as the remainder.
            if (y == '0) begin
              div_zero <= 1'b1;
              dvd      <= x;
            end else begin
              div_zero <= 1'b0;
              dvd      <= sgn ? mag16(x) : x;
            end
          end
        end
        DIV_RUN: begin
          if (div_zero) begin
            q_out <= DIV_ZERO_Q;
            r_out <= dvd;
            state <= DIV_DONE;
          end else begin
            rem <= rem_next;
            dvd <= q_mag;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              q_out <= sq ? neg16(q_mag) : q_mag;
              r_out <= sr ? neg16(rem_next) : rem_next;
              state <= DIV_DONE;
            end
          end
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

endmodule
